// File: rtl/otter_tmr_pkg.sv
// Shared constants and types for the OTTER timer bank: register offsets, CSR bit layout and the
// prescaler compare helper.
package otter_tmr_pkg;

  localparam int unsigned PS_W    = 4;
  localparam int unsigned PRESC_W = (1 << PS_W) - 1;

  localparam logic [31:0] CSR_OFS   = 32'h0000_0000;
  localparam logic [31:0] LOAD_OFS  = 32'h0000_0004;
  localparam logic [31:0] CNT_OFS   = 32'h0000_0008;
  localparam logic [31:0] STAT_OFS  = 32'h0000_0100;
  localparam logic [31:0] IEN_OFS   = 32'h0000_0104;
  localparam logic [31:0] CH_STRIDE = 32'h0000_0010;

  localparam int unsigned CSR_EN_BIT   = 0;
  localparam int unsigned CSR_MODE_BIT = 1;
  localparam int unsigned CSR_PS_LSB   = 2;
  localparam int unsigned CSR_CASC_BIT = CSR_PS_LSB + PS_W;

  // Field order matches the CSR bit layout so a zero-extending cast yields the read value.
  typedef struct packed {
    logic            casc;
    logic [PS_W-1:0] ps;
    logic            mode;
    logic            en;
  } tmr_csr_t;

  function automatic logic [PRESC_W-1:0] presc_max(input logic [PS_W-1:0] ps);
    return PRESC_W'((32'd1 << ps) - 32'd1);
  endfunction

endpackage

// File: rtl/otter_timer_bank_if.sv
// OTTER IOBUS view of the timer bank: MCU address/data/strobe in, combinational read data and
// address-hit flag out.
interface otter_timer_bank_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        HIT;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR,
                  input RD_DATA, input HIT);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR,
                  output RD_DATA, output HIT);
endinterface

// File: rtl/tmr_channel.sv
// One timer channel: CSR, LOAD, COUNT and prescaler, with a registered one-cycle expiry pulse.
// Cascade ticking is built only when OTTER_TMR_CASCADE_EN is defined.
module tmr_channel
  import otter_tmr_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter bit          CASC_OK = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_csr_we,
  input  tmr_csr_t         i_csr_wdata,
  input  logic             i_load_we,
  input  logic [CNT_W-1:0] i_load_wdata,
  input  logic             i_casc_tick,
  output tmr_csr_t         o_csr,
  output logic [CNT_W-1:0] o_load,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expire_set,
  output logic             o_expire
);

  tmr_csr_t           r_csr;
  logic [CNT_W-1:0]   r_load;
  logic [CNT_W-1:0]   r_count;
  logic [PRESC_W-1:0] r_presc;
  logic               r_expire;

  tmr_csr_t w_csr_wr;
  logic     w_casc;
  logic     w_presc_tick;
  logic     w_tick;
  logic     w_expire;

`ifdef OTTER_TMR_CASCADE_EN
  assign w_casc = CASC_OK && r_csr.casc;
  always_comb begin
    w_csr_wr      = i_csr_wdata;
    w_csr_wr.casc = CASC_OK && i_csr_wdata.casc;
  end
`else
  logic w_unused;
  assign w_unused = ^{i_casc_tick, i_csr_wdata.casc, CASC_OK};
  assign w_casc   = 1'b0;
  always_comb begin
    w_csr_wr      = i_csr_wdata;
    w_csr_wr.casc = 1'b0;
  end
`endif

  assign w_presc_tick = (r_presc == presc_max(r_csr.ps));
  assign w_tick       = r_csr.en && (w_casc ? i_casc_tick : w_presc_tick);
  assign w_expire     = w_tick && (r_count == '0);

  // A CSR write takes priority over this cycle's tick, including the one-shot EN auto-clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_csr    <= '0;
      r_load   <= '0;
      r_count  <= '0;
      r_presc  <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= w_expire;
      if (i_load_we) r_load <= i_load_wdata;
      if (i_csr_we) begin
        r_csr <= w_csr_wr;
        if (i_csr_wdata.en) begin
          r_count <= r_load;
          r_presc <= '0;
        end
      end else if (r_csr.en) begin
        r_presc <= w_presc_tick ? '0 : r_presc + PRESC_W'(1);
        if (w_expire) begin
          if (r_csr.mode) r_count  <= r_load;
          else            r_csr.en <= 1'b0;
        end else if (w_tick) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  assign o_csr        = r_csr;
  assign o_load       = r_load;
  assign o_count      = r_count;
  assign o_expire_set = w_expire;
  assign o_expire     = r_expire;

endmodule

// File: rtl/otter_timer_bank.sv
// N-channel memory-mapped timer bank on the OTTER IOBUS: address decode, read mux, W1C interrupt
// status, interrupt enable and registered INTR. Optional cascade mode: OTTER_TMR_CASCADE_EN.
module otter_timer_bank
  import otter_tmr_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h1100_D000
) (
  input  logic                CLK,
  input  logic                RESET,
  otter_timer_bank_if.slave   bus,
  output logic                INTR,
  output logic [N_CH-1:0]     EXPIRE
);

  logic [31:0]     w_ofs;
  logic [31:0]     w_rd_data;
  logic            w_hit;
  logic            w_stat_sel;
  logic            w_ien_sel;
  logic [N_CH-1:0] w_csr_we;
  logic [N_CH-1:0] w_load_we;
  logic [N_CH-1:0] w_expire_set;
  logic [N_CH-1:0] w_w1c;
  tmr_csr_t        w_csr_wdata;
  tmr_csr_t        w_csr   [N_CH];
  logic [CNT_W-1:0] w_load [N_CH];
  logic [CNT_W-1:0] w_count[N_CH];

  logic [N_CH-1:0] r_int_stat;
  logic [N_CH-1:0] r_int_en;
  logic            r_intr;

  assign w_ofs      = bus.IOBUS_ADDR - BASE_ADDR;
  assign w_stat_sel = (w_ofs == STAT_OFS);
  assign w_ien_sel  = (w_ofs == IEN_OFS);

  always_comb begin
    w_csr_wdata      = '0;
    w_csr_wdata.en   = bus.IOBUS_OUT[CSR_EN_BIT];
    w_csr_wdata.mode = bus.IOBUS_OUT[CSR_MODE_BIT];
    w_csr_wdata.ps   = bus.IOBUS_OUT[CSR_PS_LSB +: PS_W];
    w_csr_wdata.casc = bus.IOBUS_OUT[CSR_CASC_BIT];
  end

  // Exact-match decode: unmapped words inside the window neither hit nor return data.
  always_comb begin
    w_csr_we  = '0;
    w_load_we = '0;
    w_rd_data = '0;
    w_hit     = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_ofs == 32'(i) * CH_STRIDE + CSR_OFS) begin
        w_hit       = 1'b1;
        w_rd_data   = 32'(w_csr[i]);
        w_csr_we[i] = bus.IOBUS_WR;
      end
      if (w_ofs == 32'(i) * CH_STRIDE + LOAD_OFS) begin
        w_hit        = 1'b1;
        w_rd_data    = 32'(w_load[i]);
        w_load_we[i] = bus.IOBUS_WR;
      end
      if (w_ofs == 32'(i) * CH_STRIDE + CNT_OFS) begin
        w_hit     = 1'b1;
        w_rd_data = 32'(w_count[i]);
      end
    end
    if (w_stat_sel) begin
      w_hit     = 1'b1;
      w_rd_data = 32'(r_int_stat);
    end
    if (w_ien_sel) begin
      w_hit     = 1'b1;
      w_rd_data = 32'(r_int_en);
    end
  end

  assign bus.RD_DATA = w_rd_data;
  assign bus.HIT     = w_hit;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic w_casc_tick;
    if (i == 0) begin : g_first
      assign w_casc_tick = 1'b0;
    end else begin : g_next
      assign w_casc_tick = EXPIRE[i-1];
    end

    tmr_channel #(
      .CNT_W  (CNT_W),
      .CASC_OK(i != 0)
    ) u_ch (
      .CLK         (CLK),
      .RESET       (RESET),
      .i_csr_we    (w_csr_we[i]),
      .i_csr_wdata (w_csr_wdata),
      .i_load_we   (w_load_we[i]),
      .i_load_wdata(bus.IOBUS_OUT[CNT_W-1:0]),
      .i_casc_tick (w_casc_tick),
      .o_csr       (w_csr[i]),
      .o_load      (w_load[i]),
      .o_count     (w_count[i]),
      .o_expire_set(w_expire_set[i]),
      .o_expire    (EXPIRE[i])
    );
  end

  assign w_w1c = (w_stat_sel && bus.IOBUS_WR) ? bus.IOBUS_OUT[N_CH-1:0] : '0;

  // Expiry set wins over a simultaneous W1C on the same bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_int_stat <= '0;
      r_int_en   <= '0;
      r_intr     <= 1'b0;
    end else begin
      r_int_stat <= (r_int_stat & ~w_w1c) | w_expire_set;
      if (w_ien_sel && bus.IOBUS_WR) r_int_en <= bus.IOBUS_OUT[N_CH-1:0];
      r_intr <= |(r_int_stat & r_int_en);
    end
  end

  assign INTR = r_intr;

endmodule

// File: tb/tb_otter_timer_bank.sv
// Scoreboard bench for otter_timer_bank: stimulus pushes expected reads/flags and expiry events
// into queues; a negedge monitor pops and compares whenever a sample or EXPIRE pulse appears.
module tb_otter_timer_bank;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 32;
  localparam logic [31:0] BASE  = 32'h1100_D000;

  logic            CLK   = 1'b0;
  logic            RESET = 1'b1;
  logic            INTR;
  logic [N_CH-1:0] EXPIRE;

  otter_timer_bank_if bus ();

  otter_timer_bank #(
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .BASE_ADDR(BASE)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .INTR  (INTR),
    .EXPIRE(EXPIRE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 0 RD_DATA, 1 HIT, 2 INTR
    string       name;
    logic [31:0] exp;
  } smp_t;

  typedef struct {
    int              c;
    logic [N_CH-1:0] m;
  } exp_t;

  smp_t smp_q[$];
  exp_t exp_q[$];
  logic smp_req  = 1'b0;
  logic done_req = 1'b0;
  logic done_ck  = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  always @(negedge CLK) begin
    smp_t        s;
    exp_t        e;
    logic [31:0] act;
    if (smp_req) begin
      n_cmp++;
      if (smp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sample_queue: got empty queue, want an entry");
      end else begin
        s = smp_q.pop_front();
        case (s.kind)
          0:       act = bus.RD_DATA;
          1:       act = {31'b0, bus.HIT};
          default: act = {31'b0, INTR};
        endcase
        if (act !== s.exp) begin
          n_bad++;
          $display("FAIL %s: got %h want %h (cycle %0d)", s.name, act, s.exp, cyc);
        end
      end
    end
    if (EXPIRE != '0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL expire_unexpected: got %b at cycle %0d, want none", EXPIRE, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.c != cyc || e.m !== EXPIRE) begin
          n_bad++;
          $display("FAIL expire: got %b at cycle %0d, want %b at cycle %0d", EXPIRE, cyc, e.m, e.c);
        end
      end
    end
    if (done_req && !done_ck) begin
      done_ck = 1'b1;
      n_cmp++;
      if (exp_q.size() != 0 || smp_q.size() != 0) begin
        n_bad++;
        $display("FAIL pending: got %0d expiries / %0d samples outstanding, want 0 / 0",
                 exp_q.size(), smp_q.size());
      end
    end
  end

  function automatic void push_exp(input int c, input logic [N_CH-1:0] m);
    exp_t e;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].c == c) begin
        e = exp_q[i];
        e.m = e.m | m;
        exp_q[i] = e;
        return;
      end
      if (exp_q[i].c > c) begin
        e.c = c;
        e.m = m;
        exp_q.insert(i, e);
        return;
      end
    end
    e.c = c;
    e.m = m;
    exp_q.push_back(e);
  endfunction

  // All tasks enter and leave one time unit after a rising edge; each takes one cycle.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic chk(input int kind, input logic [31:0] a, input logic [31:0] e,
                     input string nm);
    smp_t s;
    s.kind = kind;
    s.name = nm;
    s.exp  = e;
    smp_q.push_back(s);
    bus.IOBUS_ADDR = a;
    smp_req = 1'b1;
    @(posedge CLK);
    #1;
    smp_req = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e;
    int          e0;
    logic [31:0] csr1_exp;
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    bus.IOBUS_WR   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Reset state of every register
    for (int ch = 0; ch < N_CH; ch++) begin
      chk(0, BASE + 32'(16 * ch) + 32'h0, 0, "rst_csr");
      chk(0, BASE + 32'(16 * ch) + 32'h4, 0, "rst_load");
      chk(0, BASE + 32'(16 * ch) + 32'h8, 0, "rst_count");
    end
    chk(0, BASE + 32'h100, 0, "rst_stat");
    chk(0, BASE + 32'h104, 0, "rst_ien");
    chk(2, BASE, 0, "rst_intr");
    chk(1, BASE + 32'h100, 1, "hit_stat");
    chk(1, BASE + 32'h0C, 0, "hit_unmapped");
    chk(1, BASE + 32'(16 * N_CH), 0, "hit_beyond_ch");

    // Ch0 periodic, LOAD rewritten mid-run, W1C races
    wr(BASE + 32'h104, 1);
    wr(BASE + 32'h4, 3);
    chk(0, BASE + 32'h4, 3, "load0_rd");
    chk(0, BASE + 32'h0C, 0, "rd_unmapped");
    e = cyc + 1;
    wr(BASE + 32'h0, 3);
    push_exp(e + 4, 4'b0001);
    push_exp(e + 8, 4'b0001);
    push_exp(e + 16, 4'b0001);
    chk(0, BASE + 32'h100, 0, "stat_before_expire");
    wait_to(e + 4);
    chk(2, BASE, 0, "intr_at_expire");
    chk(2, BASE, 1, "intr_after_expire");
    wr(BASE + 32'h4, 7);
    chk(0, BASE + 32'h100, 1, "stat_ch0");
    wait_to(e + 15);
    wr(BASE + 32'h100, 1);
    chk(0, BASE + 32'h100, 1, "stat_set_wins");
    wait_to(e + 18);
    wr(BASE + 32'h100, 1);
    chk(2, BASE, 1, "intr_trails_clear");
    chk(2, BASE, 0, "intr_dropped");
    chk(0, BASE + 32'h100, 0, "stat_cleared");
    wr(BASE + 32'h0, 2);
    chk(0, BASE + 32'h8, 1, "count0_hold");
    chk(0, BASE + 32'h0, 2, "csr0_disabled");
    chk(0, BASE + 32'h4, 7, "load0_new");

    // Ch1 one-shot, PS=2
    wr(BASE + 32'h14, 2);
    e = cyc + 1;
    wr(BASE + 32'h10, 32'h9);
    push_exp(e + 12, 4'b0010);
    wait_to(e + 12);
    chk(0, BASE + 32'h10, 32'h8, "csr1_oneshot_en_clr");
    chk(0, BASE + 32'h18, 0, "count1_zero");
    wr(BASE + 32'h18, 5);
    chk(0, BASE + 32'h18, 0, "count1_ro");
    chk(0, BASE + 32'h100, 2, "stat_ch1");
    chk(2, BASE, 0, "intr_ch1_masked");
    wr(BASE + 32'h104, 3);
    chk(2, BASE, 0, "intr_ien_lag");
    chk(2, BASE, 1, "intr_ch1_enabled");
    wr(BASE + 32'h100, 32'hF);

    // Cascade stimulus: ch1 counts ch0 expiries only when the feature is built
    wr(BASE + 32'h4, 1);
    wr(BASE + 32'h14, 2);
    wr(BASE + 32'h10, 32'h43);
    e0 = cyc + 1;
    wr(BASE + 32'h0, 3);
`ifdef OTTER_TMR_CASCADE_EN
    csr1_exp = 32'h43;
    for (int k = 7; k <= 20; k += 6) push_exp(e0 + k, 4'b0010);
`else
    csr1_exp = 32'h03;
    for (int k = 2; k <= 20; k += 3) push_exp(e0 + k, 4'b0010);
`endif
    for (int k = 2; k <= 20; k += 2) push_exp(e0 + k, 4'b0001);
    chk(0, BASE + 32'h10, csr1_exp, "csr1_casc_bit");
    wait_to(e0 + 20);
    wr(BASE + 32'h0, 0);
    wr(BASE + 32'h10, 0);

    repeat (10) @(posedge CLK);
    #1;
    done_req = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
